cp0_unit: RTL and testbench
===========================

// Module: cp0_unit
// PURPOSE
//  Parametrised CP0 register unit for the MIPS core; successor to the fixed single-timer CP0 file.
//  Holds Count/Compare/Status/Cause/EPC/BadVAddr/PRId/Config.
//  Samples HW_INT_NUM external interrupt lines and raises a registered interrupt request.
//  Commits exceptions/ERET from MEM stage; supplies exception vector to fetch.
// PARAMETERS
//  HW_INT_NUM  6            external interrupt lines (1..6), mapped to Cause.IP[2+:HW_INT_NUM]
//  COUNT_DIV   2            Count increments once per COUNT_DIV clk cycles (>=1)
//  PRID_VAL    32'h004c0102 PRId read value
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous, active-high reset
//  we_i            in   1   MTC0 write enable
//  waddr_i         in   5   MTC0 register number
//  raddr_i         in   5   MFC0 register number
//  data_i          in   32  MTC0 data
//  hw_int_i        in   HW_INT_NUM  level-sensitive external interrupts
//  exc_valid_i     in   1   exception commit strobe (one cycle)
//  exc_code_i      in   5   ExcCode for committed exception
//  eret_i          in   1   ERET commit strobe
//  pc_i            in   32  PC of committing instruction
//  in_delayslot_i  in   1   committing instruction is in a delay slot
//  badvaddr_we_i   in   1   latch badvaddr_i (AdEL/AdES only)
//  badvaddr_i      in   32  faulting address
//  data_o          out  32  MFC0 read data (combinational)
//  status_o/cause_o/epc_o out 32  live register values
//  int_req_o       out  1   registered interrupt request to commit stage
//  exc_vector_o    out  32  exception entry PC
// BEHAVIOUR
//  Reset: Count=0, Compare=0, Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, BadVAddr=0,
//   div counter=0, int_req_o=0; data_o=0 while rst.
//  Count: div counter counts 0..COUNT_DIV-1; Count+=1 (mod 2^32) on wrap; MTC0 Count loads data_i, resets div counter.
//  Timer: Cause.TI(bit30) set sticky when Count==Compare and Compare!=0; cleared by MTC0 Compare (same-cycle match: clear wins).
//  Cause.IP: [7]=hw_int_i[5] | TI when HW_INT_NUM==6, else TI; remaining hw lines sampled into IP[2+i] each cycle;
//   IP[1:0] software, written by MTC0 Cause[9:8].
//  Writable: Status IM[15:8], EXL[1], IE[0]; Cause[9:8]; EPC; Count; Compare. Other bits read-only.
//  int_req_o <= Status.IE & ~Status.EXL & |(Status.IM & Cause.IP); one-cycle latency from IP change.
//  Exception commit (exc_valid_i): if EXL==0 then EPC=pc_i (pc_i-4 if delay slot), Cause.BD=in_delayslot_i;
//   if EXL==1 EPC/BD unchanged. Always: EXL=1, Cause.ExcCode=exc_code_i; BadVAddr=badvaddr_i if badvaddr_we_i.
//  ERET: EXL=0.
//  Priority same cycle: exception > ERET > MTC0 for any overlapping bit; non-overlapping MTC0 bits still written.
//  exc_vector_o: BEV ? 32'hBFC0_0380 : 32'h8000_0180.
//  Read: reg 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config(32'h0000_8000); others 0.
//  Reset asserted mid-exception: all state returns to reset values; pending strobes ignored.
// CONFIGURATION
//  CP0_EBASE_EN defined: adds EBase (reg 15 on waddr_i/raddr_i with MTC0 data bit0 select is NOT used; mapped as reg 31),
//   reset 32'h8000_0000, bits[29:12] writable; exc_vector_o = BEV ? 32'hBFC0_0380 : {EBase[31:12],12'h180}.
//  Undefined: no EBase, reg 31 reads 0, fixed vectors as above.
// TESTING
//  COUNT_DIV=2, Compare=10 after reset -> Cause.TI=1 at Count==10 (cycle ~20); IM7=IE=1 -> int_req_o=1 next cycle; MTC0 Compare -> TI=0, int_req_o=0.
//  hw_int_i[0]=1, Status=32'h0000_0401 -> Cause.IP2=1, int_req_o=1 one cycle later; EXL=1 -> int_req_o=0.
//  exc_valid_i, code=5'h04, pc=32'hBFC0_1004, delayslot=1, badvaddr_we_i, badvaddr=32'h1 -> EPC=BFC0_1000, BD=1, ExcCode=4, BadVAddr=1, EXL=1.
//  Second exception while EXL=1, pc=32'h8000_0200 -> EPC unchanged, ExcCode updated; eret_i -> EXL=0.
//  Same cycle exc_valid_i + MTC0 Status=0 -> EXL=1, IE=0, IM=0.
//  CP0_EBASE_EN: BEV cleared, EBase=32'h8001_0000 -> exc_vector_o=32'h8001_0180.

Source files
------------

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 register file (Count/Compare/Status/Cause/EPC/BadVAddr/PRId/Config).
// Latency: MFC0 read data is combinational; interrupt request registered one cycle after Cause.IP changes.
// Backpressure: none; strobes are single-cycle commits, priority exception > ERET > MTC0 per bit.
//
// Ports: clk/rst (sync, active-high); MTC0 we_i/waddr_i/data_i; MFC0 raddr_i/data_o;
//   hw_int_i external interrupt levels; exc_valid_i/exc_code_i/pc_i/in_delayslot_i exception commit;
//   badvaddr_we_i/badvaddr_i faulting address; eret_i; live status_o/cause_o/epc_o; int_req_o; exc_vector_o.
// Optional feature: define CP0_EBASE_EN to add EBase (register 31) and an EBase-relative vector.
module cp0_unit #(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004c0102
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           data_i,
    input  logic [HW_INT_NUM-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic                  eret_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delayslot_i,
    input  logic                  badvaddr_we_i,
    input  logic [31:0]           badvaddr_i,
    output logic [31:0]           data_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_req_o,
    output logic [31:0]           exc_vector_o
);

    localparam int          DIVW    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_MAX = DIVW'(COUNT_DIV - 1);

    logic [31:0]     r_count;
    logic [31:0]     r_compare;
    logic [DIVW-1:0] r_div;
    logic [7:0]      r_im;
    logic            r_exl;
    logic            r_ie;
    logic            r_bev;
    logic            r_bd;
    logic            r_ti;
    logic [1:0]      r_ip_sw;
    logic [5:0]      r_hw;
    logic [4:0]      r_exccode;
    logic [31:0]     r_epc;
    logic [31:0]     r_badvaddr;
    logic            r_int_req;
`ifdef CP0_EBASE_EN
    logic [31:0]     r_ebase;
`endif

    logic [5:0]  w_hw_ext;
    logic [7:0]  w_ip;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;

    // Unused interrupt positions are tied low so IP[6:2] / IP[7] hardware terms vanish cleanly.
    for (genvar i = 0; i < 6; i++) begin : g_hw
        if (i < HW_INT_NUM) begin : g_on
            assign w_hw_ext[i] = hw_int_i[i];
        end else begin : g_off
            assign w_hw_ext[i] = 1'b0;
        end
    end

    // IP7 shares the timer with the sixth hardware line (zero when fewer lines exist).
    assign w_ip     = {r_hw[5] | r_ti, r_hw[4:0], r_ip_sw};
    assign w_status = {9'b0, r_bev, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

    assign w_wr_count   = we_i && (waddr_i == 5'd9);
    assign w_wr_compare = we_i && (waddr_i == 5'd11);
    assign w_wr_status  = we_i && (waddr_i == 5'd12);
    assign w_wr_cause   = we_i && (waddr_i == 5'd13);
    assign w_wr_epc     = we_i && (waddr_i == 5'd14);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_compare  <= '0;
            r_div      <= '0;
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bev      <= 1'b1;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip_sw    <= '0;
            r_hw       <= '0;
            r_exccode  <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_int_req  <= 1'b0;
`ifdef CP0_EBASE_EN
            r_ebase    <= 32'h8000_0000;
`endif
        end else begin
            // Count: prescaled by COUNT_DIV; a software load restarts the prescaler.
            if (w_wr_count) begin
                r_count <= data_i;
                r_div   <= '0;
            end else if (r_div == DIV_MAX) begin
                r_count <= r_count + 32'd1;
                r_div   <= '0;
            end else begin
                r_div   <= r_div + 1'b1;
            end

            if (w_wr_compare) r_compare <= data_i;

            // Timer flag is sticky; a Compare write clears it even on a coincident match.
            if (w_wr_compare)
                r_ti <= 1'b0;
            else if ((r_count == r_compare) && (r_compare != 32'd0))
                r_ti <= 1'b1;

            r_hw <= w_hw_ext;
            if (w_wr_cause) r_ip_sw <= data_i[9:8];

            // IM/IE have no hardware writer, so MTC0 always lands on them.
            if (w_wr_status) begin
                r_im <= data_i[15:8];
                r_ie <= data_i[0];
`ifdef CP0_EBASE_EN
                // BEV is software-clearable here so the EBase vector can be selected.
                r_bev <= data_i[22];
`endif
            end

            if (exc_valid_i)      r_exl <= 1'b1;
            else if (eret_i)      r_exl <= 1'b0;
            else if (w_wr_status) r_exl <= data_i[1];

            // Nested exceptions (EXL already set) keep the original return point.
            if (exc_valid_i) begin
                if (!r_exl) begin
                    r_epc <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    r_bd  <= in_delayslot_i;
                end
            end else if (w_wr_epc) begin
                r_epc <= data_i;
            end

            if (exc_valid_i) r_exccode <= exc_code_i;
            if (exc_valid_i && badvaddr_we_i) r_badvaddr <= badvaddr_i;

`ifdef CP0_EBASE_EN
            if (we_i && (waddr_i == 5'd31)) r_ebase[29:12] <= data_i[29:12];
`endif

            r_int_req <= r_ie & ~r_exl & (|(r_im & w_ip));
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (!rst) begin
            case (raddr_i)
                5'd8:    data_o = r_badvaddr;
                5'd9:    data_o = r_count;
                5'd11:   data_o = r_compare;
                5'd12:   data_o = w_status;
                5'd13:   data_o = w_cause;
                5'd14:   data_o = r_epc;
                5'd15:   data_o = PRID_VAL;
                5'd16:   data_o = 32'h0000_8000;
`ifdef CP0_EBASE_EN
                5'd31:   data_o = r_ebase;
`endif
                default: data_o = 32'd0;
            endcase
        end
    end

    assign status_o  = w_status;
    assign cause_o   = w_cause;
    assign epc_o     = r_epc;
    assign int_req_o = r_int_req;
`ifdef CP0_EBASE_EN
    assign exc_vector_o = r_bev ? 32'hBFC0_0380 : {r_ebase[31:12], 12'h180};
`else
    assign exc_vector_o = r_bev ? 32'hBFC0_0380 : 32'h8000_0180;
`endif

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [31:0] data_i = '0;
    logic [5:0]  hw_int_i = '0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = '0;
    logic        eret_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        in_delayslot_i = 1'b0;
    logic        badvaddr_we_i = 1'b0;
    logic [31:0] badvaddr_i = '0;
    logic [31:0] data_o, status_o, cause_o, epc_o, exc_vector_o;
    logic        int_req_o;

    int n_vec = 0;
    int n_err = 0;

    cp0_unit #(.HW_INT_NUM(6), .COUNT_DIV(2), .PRID_VAL(32'h004c0102)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .hw_int_i(hw_int_i), .exc_valid_i(exc_valid_i),
        .exc_code_i(exc_code_i), .eret_i(eret_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .badvaddr_we_i(badvaddr_we_i),
        .badvaddr_i(badvaddr_i), .data_o(data_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .int_req_o(int_req_o),
        .exc_vector_o(exc_vector_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        raddr_i = a;
        #1;
        v = data_o;
    endtask

    initial begin
        logic [31:0] v;
        bit          seen;

        // Reset: reads are forced to zero while rst is high.
        tick(); tick(); tick();
        rd(5'd15, v);                    check("rd_during_rst", v, 32'h0);
        rst = 1'b0;
        check("rst_status",  status_o,     32'h0040_0000);
        check("rst_cause",   cause_o,      32'h0);
        check("rst_epc",     epc_o,        32'h0);
        check("rst_intreq",  {31'b0, int_req_o}, 32'h0);
        check("rst_vector",  exc_vector_o, 32'hBFC0_0380);
        rd(5'd9,  v);                    check("rst_count", v, 32'h0);
        rd(5'd15, v);                    check("prid",      v, 32'h004c0102);
        rd(5'd16, v);                    check("config",    v, 32'h0000_8000);
        rd(5'd31, v);                    check("reg31_zero", v, 32'h0);
        rd(5'd3,  v);                    check("reg3_zero",  v, 32'h0);

        // Timer: TI appears one edge after Count reaches Compare, request one edge later.
        mtc0(5'd11, 32'd10);
        mtc0(5'd12, 32'h0000_8001);
        check("status_im7_ie", status_o, 32'h0040_8001);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = cause_o[30];
        end
        check("ti_seen", {31'b0, seen}, 32'h1);
        rd(5'd9, v);                     check("count_at_ti", v, 32'd10);
        check("intreq_not_yet", {31'b0, int_req_o}, 32'h0);
        tick();
        check("intreq_timer", {31'b0, int_req_o}, 32'h1);
        check("cause_ip7_ti", cause_o, 32'h4000_8000);
        mtc0(5'd11, 32'd1000);
        check("ti_cleared", {31'b0, cause_o[30]}, 32'h0);
        tick();
        check("intreq_dropped", {31'b0, int_req_o}, 32'h0);

        // Count load and wrap with the divide-by-two prescaler.
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, v);                     check("count_loaded", v, 32'hFFFF_FFFF);
        tick();
        rd(5'd9, v);                     check("count_hold", v, 32'hFFFF_FFFF);
        tick();
        rd(5'd9, v);                     check("count_wrap", v, 32'h0);

        // Hardware line 0 -> IP2, request one cycle later, EXL masks.
        mtc0(5'd12, 32'h0000_0401);
        hw_int_i = 6'b000001;
        tick();
        check("cause_ip2", cause_o, 32'h0000_0400);
        check("intreq_ip2_lat", {31'b0, int_req_o}, 32'h0);
        tick();
        check("intreq_ip2", {31'b0, int_req_o}, 32'h1);
        mtc0(5'd12, 32'h0000_0403);
        check("status_exl_set", status_o, 32'h0040_0403);
        tick();
        check("intreq_exl_mask", {31'b0, int_req_o}, 32'h0);
        hw_int_i = 6'b100000;
        tick();
        check("cause_hw5_ip7", cause_o, 32'h0000_8000);
        hw_int_i = 6'b000000;
        mtc0(5'd12, 32'h0);
        check("cause_hw_clear", cause_o, 32'h0);

        // Software IP bits are the only writable Cause bits.
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_sw_only", cause_o, 32'h0000_0300);
        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'hFFFF_FFFF);
        check("status_ro_bits", status_o, 32'h0040_FF03);
        mtc0(5'd12, 32'h0);

        // Exception in a delay slot with BadVAddr capture.
        exc_valid_i = 1'b1; exc_code_i = 5'h04; pc_i = 32'hBFC0_1004;
        in_delayslot_i = 1'b1; badvaddr_we_i = 1'b1; badvaddr_i = 32'h1;
        tick();
        exc_valid_i = 1'b0; badvaddr_we_i = 1'b0; in_delayslot_i = 1'b0;
        check("exc1_epc",    epc_o,    32'hBFC0_1000);
        check("exc1_cause",  cause_o,  32'h8000_0010);
        check("exc1_status", status_o, 32'h0040_0002);
        rd(5'd8, v);                     check("exc1_badvaddr", v, 32'h1);

        // Nested exception: EPC/BD kept, ExcCode updated, BadVAddr untouched.
        exc_valid_i = 1'b1; exc_code_i = 5'h0C; pc_i = 32'h8000_0200;
        badvaddr_i = 32'hDEAD_BEEF;
        tick();
        exc_valid_i = 1'b0;
        check("exc2_epc",   epc_o,   32'hBFC0_1000);
        check("exc2_cause", cause_o, 32'h8000_0030);
        rd(5'd8, v);                     check("exc2_badvaddr", v, 32'h1);
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        check("eret_status", status_o, 32'h0040_0000);

        // Exception and MTC0 Status in the same cycle.
        mtc0(5'd12, 32'h0000_FF01);
        exc_valid_i = 1'b1; exc_code_i = 5'h00; pc_i = 32'h0000_0100;
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
        tick();
        exc_valid_i = 1'b0; we_i = 1'b0;
        check("exc_mtc0_status", status_o, 32'h0040_0002);
        check("exc_mtc0_epc",    epc_o,    32'h0000_0100);
        check("exc_mtc0_cause",  cause_o,  32'h0);

        // ERET beats MTC0 on EXL; IE still written.
        eret_i = 1'b1; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000_0003;
        tick();
        eret_i = 1'b0; we_i = 1'b0;
        check("eret_mtc0_status", status_o, 32'h0040_0001);

        // Exception beats MTC0 EPC.
        exc_valid_i = 1'b1; pc_i = 32'h0000_0400;
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h1234_5678;
        tick();
        exc_valid_i = 1'b0; we_i = 1'b0;
        check("exc_mtc0_epc_win", epc_o, 32'h0000_0400);
        mtc0(5'd14, 32'h1234_5678);
        rd(5'd14, v);                    check("mtc0_epc", v, 32'h1234_5678);

        // Reset coinciding with an exception strobe.
        rst = 1'b1; exc_valid_i = 1'b1; pc_i = 32'h0000_0800;
        tick();
        rst = 1'b0; exc_valid_i = 1'b0;
        check("rst_mid_status", status_o, 32'h0040_0000);
        check("rst_mid_epc",    epc_o,    32'h0);
        check("rst_mid_cause",  cause_o,  32'h0);
        check("rst_mid_vector", exc_vector_o, 32'hBFC0_0380);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
